// File: rtl/stream_decrypt.sv
// Byte-serial framed stream decryptor: p = c - k, key steps by KEY_STEP per byte
// and restarts at KEY_SEED at every frame boundary. One registered output stage.
module stream_decrypt #(
  parameter int          MSG_LEN  = 9,
  parameter logic [7:0]  KEY_SEED = 8'h05,
  parameter logic [7:0]  KEY_STEP = 8'h03
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       m_valid,
  output logic [7:0] m_data,
  output logic       m_last,
  input  logic       m_ready,
  output logic       frame_done,
  output logic       frame_err
);
  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       key_q, key_d;
  logic             m_valid_q, m_valid_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;

  logic in_beat, at_end, close;

  // A slot frees up whenever the held byte is being taken this cycle.
  assign s_ready = !m_valid_q || m_ready;
  assign in_beat = s_valid && s_ready;
  assign at_end  = (idx_q == LAST_IDX);
  assign close   = s_last || at_end;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    key_d        = key_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (in_beat) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data - key_q;
      m_last_d  = close;
      if (close) begin
        // Error when the sender's view of the frame end disagrees with the count.
        frame_done_d = 1'b1;
        frame_err_d  = (s_last != at_end);
        idx_d        = '0;
        key_d        = KEY_SEED;
        state_d      = IDLE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        key_d   = key_q + KEY_STEP;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      key_q        <= KEY_SEED;
      m_valid_q    <= 1'b0;
      m_data_q     <= 8'h00;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      key_q        <= key_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_stream_decrypt.sv
// Bench for stream_decrypt: two instances (default and a short-frame, wrapping-key
// variant) fed the same stream, each checked every cycle against a frame-position model.
module tb_stream_decrypt;
  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_last, m_ready;
  logic [7:0] s_data;
  logic [1:0] s_ready_w, m_valid_w, m_last_w, fd_w, fe_w;
  logic [1:0][7:0] m_data_w;

  always #5 clk = ~clk;

  stream_decrypt dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_w[0]), .m_valid(m_valid_w[0]), .m_data(m_data_w[0]),
    .m_last(m_last_w[0]), .m_ready(m_ready), .frame_done(fd_w[0]), .frame_err(fe_w[0]));

  stream_decrypt #(.MSG_LEN(3), .KEY_SEED(8'hFE), .KEY_STEP(8'h03)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready_w[1]), .m_valid(m_valid_w[1]), .m_data(m_data_w[1]),
    .m_last(m_last_w[1]), .m_ready(m_ready), .frame_done(fd_w[1]), .frame_err(fe_w[1]));

  int nchk = 0, nerr = 0;
  int cyc = 0;
  int LEN [2] = '{9, 3};
  int SEED[2] = '{5, 254};
  int STEP[2] = '{3, 3};

  // Model: frame position per instance plus the single pending output byte.
  int       pos [2];
  bit       ev  [2];
  bit [7:0] ed  [2];
  bit       el  [2];
  bit       edn [2];
  bit       eer [2];

  logic [7:0] got0[$];
  logic [7:0] got1[$];
  int errcnt0 = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        pos[i] = 0; ev[i] = 0; ed[i] = 0; el[i] = 0; edn[i] = 0; eer[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        bit inb, at_end, cl;
        inb = s_valid && (!ev[i] || m_ready);
        if (inb) begin
          at_end = (pos[i] == LEN[i] - 1);
          cl     = s_last || at_end;
          ev[i]  = 1;
          ed[i]  = 8'(int'(s_data) - (SEED[i] + pos[i] * STEP[i]));
          el[i]  = cl;
          edn[i] = cl;
          eer[i] = cl && (s_last != at_end);
          pos[i] = cl ? 0 : pos[i] + 1;
        end else begin
          if (m_ready) ev[i] = 0;
          edn[i] = 0;
          eer[i] = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && m_valid_w[0] && m_ready) got0.push_back(m_data_w[0]);
    if (rst_n && m_valid_w[1] && m_ready) got1.push_back(m_data_w[1]);
    if (rst_n && fe_w[0]) errcnt0++;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m_valid[%0d]", i), m_valid_w[i], ev[i]);
      chk($sformatf("s_ready[%0d]", i), s_ready_w[i], !ev[i] || m_ready);
      chk($sformatf("frame_done[%0d]", i), fd_w[i], edn[i]);
      chk($sformatf("frame_err[%0d]", i), fe_w[i], eer[i]);
      if (ev[i]) begin
        chk($sformatf("m_data[%0d]", i), m_data_w[i], ed[i]);
        chk($sformatf("m_last[%0d]", i), m_last_w[i], el[i]);
      end else if (!rst_n) begin
        chk($sformatf("rst m_data[%0d]", i), m_data_w[i], 0);
        chk($sformatf("rst m_last[%0d]", i), m_last_w[i], 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    bit acc;
    int n = 0;
    s_valid = 1; s_data = d; s_last = l;
    do begin
      @(negedge clk); acc = s_ready_w[0];
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send timeout", 0, 1);
    s_valid = 0;
  endtask

  logic [7:0] ct [9] = '{8'h58, 8'h5D, 8'h5B, 8'h53, 8'h63, 8'h69, 8'h6A, 8'h5F, 8'h6F};
  logic [7:0] pt [9] = '{8'h53, 8'h55, 8'h50, 8'h45, 8'h52, 8'h55, 8'h53, 8'h45, 8'h52};

  initial begin
    int base, c0, e0;
    rst_n = 0; s_valid = 0; s_data = 0; s_last = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Wrap cases: 02-05 = FD on dut0; dut1 byte1 key FE+3 = 01, 01-01 = 00.
    send(8'h02, 0); send(8'h01, 1);
    @(posedge clk); #1;
    chk("wrap byte0 dut0", got0[0], 8'hFD);
    chk("key wrap byte1 dut1", got1[1], 8'h00);

    // Two back-to-back frames at full rate.
    base = got0.size(); c0 = cyc;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 9; i++) send(ct[i], i == 8);
    chk("18 beats in 18 cycles", cyc - c0, 18);
    @(posedge clk); #1;
    chk("frame pair count", got0.size() - base, 18);
    for (int i = 0; i < 18; i++) chk($sformatf("superuser[%0d]", i), got0[base + i], pt[i % 9]);

    // Backpressure mid-frame.
    base = got0.size();
    for (int i = 0; i < 3; i++) send(ct[i], 0);
    m_ready = 0; s_valid = 1; s_data = ct[3]; s_last = 0;
    repeat (5) begin @(posedge clk); #1; end
    m_ready = 1;
    for (int i = 3; i < 9; i++) send(ct[i], i == 8);
    @(posedge clk); #1;
    chk("bp count", got0.size() - base, 9);
    for (int i = 0; i < 9; i++) chk($sformatf("bp byte[%0d]", i), got0[base + i], pt[i]);

    // Early s_last on byte 4, then key restarts.
    e0 = errcnt0; base = got0.size();
    for (int i = 0; i < 4; i++) send(ct[i], i == 3);
    send(8'h58, 0);
    @(posedge clk); #1;
    chk("early last err pulses", errcnt0 - e0, 1);
    chk("restart after early last", got0[base + 4], 8'h53);
    // Missing s_last at byte 9 (byte 0 already sent above).
    e0 = errcnt0;
    for (int i = 1; i < 9; i++) send(ct[i], 0);
    @(posedge clk); #1;
    chk("missing last err pulses", errcnt0 - e0, 1);

    // Reset mid-frame.
    for (int i = 0; i < 3; i++) send(ct[i], 0);
    rst_n = 0;
    #1 chk("async m_valid drop", m_valid_w[0], 0);
    @(posedge clk); #1 rst_n = 1;
    send(8'h58, 0);
    @(posedge clk); #1;
    chk("post reset byte0", got0[got0.size() - 1], 8'h53);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 9) == 0);
      @(posedge clk); #1;
    end
    s_valid = 0; m_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
